multicycle_shifter: RTL

Parametrised, sequential successor to the single-step combinational shifter in the micro-1 datapath. Performs multi-position shifts and rotates on a WIDTH-bit word, one bit position per clock, under a start/ready/done handshake. The carry-out is the last bit shifted out. Sits beside the ALU and is driven by the sequencer for SHIFT-by-N microinstructions.

---
 rtl/multicycle_shifter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_shifter
// Purpose  : Sequential shift/rotate unit. Performs multi-position shifts and
//            rotates one bit per clock under a start/ready/done handshake.
//            EXT, SWAP and zero-amount requests complete in a single edge.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_LL   = 3'd0;
  localparam logic [2:0] OP_RL   = 3'd1;
  localparam logic [2:0] OP_LA   = 3'd2;
  localparam logic [2:0] OP_RA   = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_EXT  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             cout_q,  cout_d;
  logic [2:0]       op_q,    op_d;
  logic             cin_q,   cin_d;
  logic [AMT_W-1:0] count_q, count_d;

  // Next-state, datapath step and start-accept logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cout_d  = cout_q;
    op_d    = op_q;
    cin_d   = cin_q;
    count_d = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // The DONE cycle is also a ready cycle so back-to-back requests
        // proceed without a bubble; otherwise DONE falls back to IDLE.
        state_d = S_IDLE;
        if (start) begin
          data_d  = in;
          op_d    = operation;
          cin_d   = cin;
          count_d = amount;
          cout_d  = 1'b0;
          if (operation == OP_EXT) begin
            data_d  = {{HALF{in[HALF-1]}}, in[HALF-1:0]};
            cout_d  = in[HALF-1];
            state_d = S_DONE;
          end else if (operation == OP_SWAP) begin
            data_d  = {in[HALF-1:0], in[WIDTH-1:HALF]};
            state_d = S_DONE;
          end else if (amount == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (flush) begin
          // Abandon the operation; the partial result stays in place.
          state_d = S_IDLE;
        end else begin
          case (op_q)
            OP_LL:   {cout_d, data_d} = {data_q, cin_q};
            OP_RL:   {data_d, cout_d} = {cin_q, data_q};
            OP_LA: begin
              data_d = {data_q[WIDTH-1], data_q[WIDTH-3:0], cin_q};
              cout_d = data_q[WIDTH-2];
            end
            OP_RA: begin
              data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
              cout_d = data_q[0];
            end
            OP_ROL: begin
              data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
              cout_d = data_q[WIDTH-1];
            end
            OP_ROR: begin
              data_d = {data_q[0], data_q[WIDTH-1:1]};
              cout_d = data_q[0];
            end
            default: begin
              // EXT/SWAP never enter SHIFT; hold the register.
              data_d = data_q;
            end
          endcase
          count_d = count_q - 1'b1;
          if (count_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cout_q  <= 1'b0;
      op_q    <= OP_LL;
      cin_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      count_q <= count_d;
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign out   = data_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire
